apb_mem_responder: RTL and testbench

//  APB completer: the responder end of the bus on which the processor's data-memory port initiates transfers.

---
 rtl/apb_pkg.sv | 10 +
 rtl/apb_wait_counter.sv | 27 ++
 rtl/apb_mem_responder.sv | 112 +++++++++++
 tb/tb_apb_mem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB completer types and default bus widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;
    localparam int unsigned WCNT_W     = 4;

    typedef enum logic {IDLE, ACCESS} apb_state_t;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: loaded at setup, counts down during ACCESS, flags zero.
module apb_wait_counter
    import apb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [WCNT_W-1:0] init,
    output logic              zero
);

    logic [WCNT_W-1:0] wcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q <= '0;
        end else if (load) begin
            wcnt_q <= init;
        end else if (en && (wcnt_q != '0)) begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
        end
    end

    assign zero = (wcnt_q == '0);

endmodule

// File: rtl/apb_mem_responder.sv
// APB completer backed by a flat register-array memory, with programmable
// wait states and PSLVERR on out-of-range addresses.
module apb_mem_responder
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              load;
    logic              cnt_en;
    logic              mem_we;
    logic              wcnt_zero;
    logic              err;
    logic [IDX_W-1:0]  idx;

    apb_wait_counter u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (cnt_en),
        .init (WCNT_W'(WAIT_STATES)),
        .zero (wcnt_zero)
    );

    // Range check at full address width so high addresses never alias.
    assign err     = (32'(addr_q) >= 32'(DEPTH));
    assign idx     = addr_q[IDX_W-1:0];
    assign pready  = (state_q == ACCESS) && wcnt_zero;
    assign pslverr = pready && err;
    assign prdata  = (pready && !write_q && !err) ? mem_q[idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        cnt_en  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // Access phase without a preceding setup phase is ignored.
                if (psel && !penable) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                if (pready) begin
                    state_d = IDLE;
                    mem_we  = write_q && !err;
                end else if (!psel) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture at the setup edge; later bus changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (load) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            write_q <= pwrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_mem_responder.sv
// Scoreboard bench: three completers with WAIT_STATES 1, 0 and 3 on a shared bus.
module tb_apb_mem_responder;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    localparam int WS [3] = '{1, 0, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = '0;
    logic [7:0] pwdata = '0;
    logic       psel_v    [3] = '{1'b0, 1'b0, 1'b0};
    logic       pready_v  [3];
    logic       pslverr_v [3];
    logic [7:0] prdata_v  [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]));

    apb_mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]));

    apb_mem_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
        .pslverr(pslverr_v[2]));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop(input int i, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '{0, 1'b0, 8'h00};
        case (i)
            0:       if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
            1:       if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
            default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
        endcase
    endtask

    // Monitor: every completed transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (pready_v[i]) begin
                    exp_t e;
                    bit   ok;
                    pop(i, e, ok);
                    if (!ok) begin
                        check($sformatf("unexpected_pready[%0d]", i), 1, 0);
                    end else begin
                        check($sformatf("latency[%0d]", i), cyc, e.cyc);
                        check($sformatf("pslverr[%0d]", i), int'(pslverr_v[i]), int'(e.err));
                        check($sformatf("prdata[%0d]", i), int'(prdata_v[i]), int'(e.rdata));
                    end
                end
            end
        end
    end

    // Called just after a posedge; returns just after the completing edge.
    task automatic xfer(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input logic exp_err, input logic [7:0] exp_rd);
        exp_t e;
        bit   done;
        psel_v[i] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = a;
        pwdata    = d;
        @(posedge clk); #1;
        e.cyc   = cyc + WS[i];
        e.err   = exp_err;
        e.rdata = wr ? 8'h00 : exp_rd;
        push(i, e);
        penable = 1'b1;
        paddr   = ~a;
        pwdata  = ~d;
        pwrite  = ~wr;
        done    = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (pready_v[i]) done = 1'b1;
        end
        if (!done) check($sformatf("timeout[%0d]", i), 0, 1);
        @(posedge clk); #1;
        psel_v[i] = 1'b0;
        penable   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_pready[%0d]", i), int'(pready_v[i]), 0);
            check($sformatf("rst_pslverr[%0d]", i), int'(pslverr_v[i]), 0);
            check($sformatf("rst_prdata[%0d]", i), int'(prdata_v[i]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic write/read with one wait state
        xfer(0, 1'b1, 8'h05, 8'h3C, 1'b0, 8'h00);
        xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h3C);

        // Zero wait states, back to back
        xfer(1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00);
        xfer(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5);

        // Out-of-range write, last valid word, neighbour unaffected
        xfer(0, 1'b1, 8'h80, 8'hFF, 1'b1, 8'h00);
        xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        xfer(0, 1'b1, 8'h7F, 8'h5A, 1'b0, 8'h00);
        xfer(0, 1'b0, 8'h7F, 8'h00, 1'b0, 8'h5A);

        // Out-of-range reads
        xfer(1, 1'b0, 8'h90, 8'h00, 1'b1, 8'h00);
        xfer(1, 1'b1, 8'hFF, 8'h33, 1'b1, 8'h00);
        xfer(1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00);

        // Access phase without setup must be ignored
        psel_v[1] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        psel_v[1] = 1'b0; penable = 1'b0;
        xfer(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5);

        // Aborted write with three wait states
        psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h77;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel_v[2] = 1'b0;
        @(posedge clk); #1;
        penable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        xfer(2, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00);
        xfer(2, 1'b1, 8'h02, 8'h77, 1'b0, 8'h00);
        xfer(2, 1'b0, 8'h02, 8'h00, 1'b0, 8'h77);

        // Reset in the middle of a read
        xfer(0, 1'b1, 8'h01, 8'h11, 1'b0, 8'h00);
        xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h11);
        psel_v[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h01;
        @(posedge clk); #1;
        penable = 1'b1;
        rst     = 1'b1;
        #1;
        check("midrst_pready", int'(pready_v[0]), 0);
        check("midrst_prdata", int'(prdata_v[0]), 0);
        @(posedge clk); #1;
        psel_v[0] = 1'b0; penable = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00);
        xfer(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        check("pending_q0", q0.size(), 0);
        check("pending_q1", q1.size(), 0);
        check("pending_q2", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
